// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Types and constants shared by fetch and decode of the 16-bit CPU.
// Revision    : 1.0
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;
    localparam logic [PC_W-1:0] PC_STEP = 16'd2;

    // Instruction field slices: op[15:12], rs[11:10], rt[9:8], rd/imm[7:0]
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RS_HI  = 11;
    localparam int RS_LO  = 10;
    localparam int RT_HI  = 9;
    localparam int RT_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_FETCH   = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [OP_HI-OP_LO:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry FIFO of {pc, instr} words between fetch and decode.
// Revision    : 1.0
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  fetch_entry_t               wr_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr];
    assign count  = r_count;

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner and instruction fetcher with redirect and FIFO buffer.
//               Define FETCH_STALL_CNT_EN to add the stall_cycles counter.
// Revision    : 1.0
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] PC_RESET = 16'h0000
)(
    input  logic               clock,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    input  logic               ir_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  c_pc_reset = {PC_RESET[PC_W-1:1], 1'b0};

    fetch_state_t     r_state;
    logic [PC_W-1:0]  r_imem_addr;
    logic [PC_W-1:0]  r_pend_addr;
    logic [PC_W-1:0]  w_target;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_room;
    fetch_entry_t     w_head;
    fetch_entry_t     w_wr_entry;

    assign w_target     = redirect_pc & ~16'h0001;
    assign w_push       = (r_state == FETCH_FETCH) & imem_ack & ~redirect & ~w_full;
    assign w_pop        = ~w_empty & ir_ready;
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_room       = (w_count_next < c_depth);
    assign w_wr_entry   = '{pc: r_imem_addr, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (w_push),
        .wr_entry (w_wr_entry),
        .pop      (w_pop),
        .flush    (redirect),
        .head     (w_head),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    // DISCARD keeps the abandoned request on the bus until acked; the
    // redirect target waits in r_pend_addr meanwhile.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= FETCH_IDLE;
            r_imem_addr <= c_pc_reset;
            r_pend_addr <= c_pc_reset;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (redirect) begin
                        r_imem_addr <= w_target;
                        r_state     <= FETCH_FETCH;
                    end else if (w_room) begin
                        r_state <= FETCH_FETCH;
                    end
                end
                FETCH_FETCH: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            r_imem_addr <= w_target;
                        end else begin
                            r_pend_addr <= w_target;
                            r_state     <= FETCH_DISCARD;
                        end
                    end else if (imem_ack) begin
                        r_imem_addr <= r_imem_addr + PC_STEP;
                        if (!w_room) begin
                            r_state <= FETCH_IDLE;
                        end
                    end
                end
                FETCH_DISCARD: begin
                    if (imem_ack) begin
                        r_imem_addr <= redirect ? w_target : r_pend_addr;
                        r_state     <= FETCH_FETCH;
                    end else if (redirect) begin
                        r_pend_addr <= w_target;
                    end
                end
                default: begin
                    r_state <= FETCH_IDLE;
                end
            endcase
        end
    end

    assign imem_req  = (r_state != FETCH_IDLE);
    assign imem_addr = r_imem_addr;
    assign ir_valid  = ~w_empty;
    assign ir        = w_head.instr;
    assign ir_pc     = w_head.pc;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (w_empty && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Scoreboard bench for instr_fetch_unit with a variable-latency memory.
// Revision    : 1.0
// ============================================================================
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    int lat   = 0;
    int wait_cnt;
    logic [15:0] sb_q [$];

    always #5 clock = ~clock;

    instr_fetch_unit #(
        .DEPTH    (2),
        .PC_RESET (16'h0000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [15:0] instr_of(input logic [15:0] pc);
        return {pc[7:0], pc[15:8]} ^ 16'h5A3C;
    endfunction

    // Memory: acks after `lat` wait cycles, zero latency acks combinationally.
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = imem_ack ? instr_of(imem_addr) : 16'hDEAD;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)                  wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted word must match the queue head.
    always @(negedge clock) begin
        if (reset_n && ir_valid && ir_ready) begin
            pops++;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_extra_word actual_pc=%0h required=none", ir_pc);
            end else begin
                logic [15:0] exp_pc;
                exp_pc = sb_q.pop_front();
                check("sb_ir_pc", {16'h0, ir_pc}, {16'h0, exp_pc});
                check("sb_ir", {16'h0, ir}, {16'h0, instr_of(exp_pc)});
            end
        end
    end

    // Request must hold with a stable address until acked.
    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    always @(negedge clock) begin
        if (reset_n && prev_wait)
            check("req_held", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, prev_addr});
        prev_wait = reset_n && imem_req && !imem_ack;
        prev_addr = imem_addr;
    end

`ifdef FETCH_STALL_CNT_EN
    int stall_model = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            stall_model = 0;
        end else begin
            check("stall_cycles", {16'h0, stall_cycles}, 32'(stall_model));
            if (!ir_valid) stall_model++;
        end
    end
`endif

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_req"},  {31'h0, imem_req}, 32'h0);
        check({tag, "_imem_addr"}, {16'h0, imem_addr}, 32'h0);
        check({tag, "_ir_valid"},  {31'h0, ir_valid}, 32'h0);
        check({tag, "_ir"},        {16'h0, ir}, 32'h0);
        check({tag, "_ir_pc"},     {16'h0, ir_pc}, 32'h0);
    endtask

    // Leaves the bench just after the release edge (cycle 0).
    task automatic do_reset(input int l, input logic rdy);
        reset_n  = 1'b0;
        redirect = 1'b0;
        ir_ready = rdy;
        lat      = l;
        sb_q.delete();
        repeat (2) tick();
        pops    = 0;
        reset_n = 1'b1;
    endtask

    task automatic wait_pops(input string name, input int n);
        int budget;
        budget = 300;
        while (pops < n && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        check(name, 32'(pops), 32'(n));
        #1 ir_ready = 1'b0;
    endtask

    task automatic drain_check(input string name);
        repeat (3) tick();
        check(name, 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        ir_ready    = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");

        // Zero-latency streaming: first word in cycle 2, one per cycle.
        sb_q.push_back(16'h0000); sb_q.push_back(16'h0002);
        sb_q.push_back(16'h0004); sb_q.push_back(16'h0006);
        ir_ready = 1'b1;
        pops     = 0;
        reset_n  = 1'b1;
        tick();
        check("t1_req_c1",   {31'h0, imem_req}, 32'h1);
        check("t1_addr_c1",  {16'h0, imem_addr}, 32'h0);
        check("t1_valid_c1", {31'h0, ir_valid}, 32'h0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("t1_valid_stream", {31'h0, ir_valid}, 32'h1);
        end
        tick();
        ir_ready = 1'b0;
        check("t1_pops", 32'(pops), 32'd4);
        drain_check("t1_drained");

        // Back-pressure: FIFO fills, request drops, resumes at 4.
        do_reset(0, 1'b0);
        repeat (4) tick();
        check("t2_req_full",  {31'h0, imem_req}, 32'h0);
        check("t2_valid",     {31'h0, ir_valid}, 32'h1);
        check("t2_head_held", {16'h0, ir_pc}, 32'h0);
        sb_q.push_back(16'h0000); sb_q.push_back(16'h0002); sb_q.push_back(16'h0004);
        ir_ready = 1'b1;
        tick();
        check("t2_resume_req",  {31'h0, imem_req}, 32'h1);
        check("t2_resume_addr", {16'h0, imem_addr}, 32'h4);
        tick();
        tick();
        ir_ready = 1'b0;
        drain_check("t2_drained");

        // Redirect during a 3-cycle wait: old request finished and dropped.
        do_reset(3, 1'b1);
        sb_q.push_back(16'h0040); sb_q.push_back(16'h0042);
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 16'h0041;
        tick();
        redirect = 1'b0;
        check("t3_hold_addr", {16'h0, imem_addr}, 32'h0);
        tick();
        tick();
        check("t3_new_req",   {31'h0, imem_req}, 32'h1);
        check("t3_new_addr",  {16'h0, imem_addr}, 32'h40);
        check("t3_no_valid",  {31'h0, ir_valid}, 32'h0);
        wait_pops("t3_pops", 2);
        drain_check("t3_drained");

        // Redirect together with ack and pop.
        do_reset(0, 1'b1);
        sb_q.push_back(16'h0000); sb_q.push_back(16'h0002);
        sb_q.push_back(16'h0100); sb_q.push_back(16'h0102);
        repeat (3) tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check("t4_flushed", {31'h0, ir_valid}, 32'h0);
        check("t4_addr",    {16'h0, imem_addr}, 32'h100);
        wait_pops("t4_pops", 4);
        drain_check("t4_drained");

        // Address wrap across 16'hFFFE.
        do_reset(0, 1'b1);
        sb_q.push_back(16'hFFFC); sb_q.push_back(16'hFFFE); sb_q.push_back(16'h0000);
        tick();
        redirect = 1'b1; redirect_pc = 16'hFFFC;
        tick();
        redirect = 1'b0;
        check("t5_addr", {16'h0, imem_addr}, 32'hFFFC);
        wait_pops("t5_pops", 3);
        drain_check("t5_drained");

`ifdef FETCH_STALL_CNT_EN
        // Stall counting with 2-cycle memory, checked continuously.
        do_reset(2, 1'b1);
        sb_q.push_back(16'h0000); sb_q.push_back(16'h0002);
        sb_q.push_back(16'h0004); sb_q.push_back(16'h0006);
        wait_pops("t7_pops", 4);
        drain_check("t7_drained");
`endif

        // Asynchronous reset mid-fetch.
        do_reset(2, 1'b0);
        repeat (6) tick();
        check("t6_pre_valid", {31'h0, ir_valid}, 32'h1);
        #2 reset_n = 1'b0;
        #1 check_reset_values("t6_async");
        sb_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end stage of the 16-bit single-cycle CPU. It sits directly upstream of instruction decode and register read. It owns the PC, fetches 16-bit instruction words from a variable-latency instruction memory over a req/ack interface, and buffers them in a small FIFO. It delivers them to decode over a valid/ready handshake, and supports PC redirect for branches and jumps.

## Interface
- DEPTH, 2: FIFO entries; power of two, ≥2
- PC_RESET, 16'h0000: byte address of the first fetch
- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held high with imem_addr stable until imem_ack
- imem_addr  out  16  byte address; bit 0 always 0
- imem_ack  in  1  request complete; may assert in the same cycle as imem_req
- imem_rdata  in  16  instruction word; valid only when imem_ack=1
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc
- redirect_pc  in  16  target byte address; bit 0 ignored (forced 0)
- ir_valid  out  1  FIFO head valid
- ir  out  16  FIFO head instruction (op[15:12], rs[11:10], rt[9:8], rd/imm below)
- ir_pc  out  16  byte address of ir
- ir_ready  in  1  decode accepts head when ir_valid & ir_ready
- stall_cycles  out  16  present only with FETCH_STALL_CNT_EN

## Operation
- FSM: IDLE, FETCH, DISCARD.
- IDLE: imem_req=0. Go to FETCH when count_next < DEPTH.
- FETCH: imem_req=1.
  - On ack: push {imem_rdata, imem_addr} and set imem_addr += 2 (16-bit wrap: 16'hFFFE → 16'h0000).
  - Stay in FETCH if count_next < DEPTH, else go to IDLE.
- count_next = count + push − pop. A request is only ever raised with a free slot. At most one request is outstanding.
- Redirect (any state): flush the FIFO (count=0, ir_valid=0 next cycle) and set fetch address to {redirect_pc[15:1],1'b0}.
  - If imem_req=1 and imem_ack=0, go to DISCARD. Hold the old imem_addr and req until ack, drop that data, then go to FETCH with the new address.
  - If ack arrives in the same cycle as redirect, drop that data; next cycle go to FETCH at the new address.
  - If ack arrives while in DISCARD together with a second redirect, the latest redirect_pc wins.
- Redirect and pop in the same cycle: the pop completes (decode owns that word); all remaining entries are flushed.
- Push and pop in the same cycle with FIFO full: not possible, because the request was not issued.
- ir and ir_pc are held stable while ir_valid & !ir_ready.

## Timing
- Reset values: imem_req=0, imem_addr=PC_RESET, ir_valid=0, ir=0, ir_pc=0, state IDLE, count=0, stall_cycles=0.
- First cycle after reset_n rises: imem_req=1, addr=PC_RESET.
- Reset asserted mid-operation clears everything immediately. Any outstanding memory transaction is abandoned, and the memory is also reset.
- Latency: ack in cycle N → ir_valid=1 with that word in cycle N+1.
- Throughput: 1 instruction/cycle with zero-wait memory and ir_ready=1. Each wait state costs one cycle.
- Redirect in cycle N with no outstanding request → imem_req at redirect_pc in cycle N+1. The first redirected word appears at N+2 at the earliest.

## Configuration
- FETCH_STALL_CNT_EN defined:
  - stall_cycles port exists.
  - It increments, saturating at 16'hFFFF, in every cycle where ir_valid=0 and reset_n=1.
  - Redirect does not clear it.
- Not defined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - the fetch FSM state enum (FETCH_IDLE, FETCH_FETCH, FETCH_DISCARD)
  - INSTR_W=16 and PC_STEP=2
  - the opcode field slice constants shared with decode
- One sub-module, fetch_fifo: parameterised DEPTH, width 32 ({pc, instr}), with push, pop, flush, count, full and empty.
- The FSM and PC live in the top module.

## Test plan
- Reset, zero-latency ack, ir_ready=1 → ir_pc sequence 0,2,4,6 on consecutive cycles, one word per cycle, first valid at cycle 2 after reset release.
- Hold ir_ready=0 with DEPTH=2 → two entries captured, then imem_req drops to 0. Raise ir_ready → words 0,2 emerge in order and fetching resumes at 4.
- Memory with 3-cycle latency, redirect to 16'h0041 during the wait → old request held to ack and its data discarded. Next request at 16'h0040, and the first ir_pc is 16'h0040.
- Redirect coincident with ack and with pop → popped word delivered once, acked word never appears, fetch restarts at the target.
- Redirect to 16'hFFFC → ir_pc sequence FFFC, FFFE, 0000.
- With FETCH_STALL_CNT_EN, memory with 2-cycle latency, 4 instructions fetched → stall_cycles equals the count of cycles with ir_valid=0 since reset release. Assert reset_n mid-fetch → all outputs return to reset values in the same cycle.
